// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the SRAM frame-buffer scan-out reader.
package frame_reader_pkg;

    localparam int H_RES_C = 320;
    localparam int V_RES_C = 240;

    typedef logic [15:0] pixel_t;
    typedef logic [17:0] sram_addr_t;

    typedef enum logic {
        SLOT_READ  = 1'b0,
        SLOT_WRITE = 1'b1
    } slot_e;

    typedef struct packed {
        sram_addr_t addr;
        pixel_t     data;
    } wr_entry_t;

    // y*320 + x without a multiplier; the largest result (76799) fits in 18 bits.
    function automatic sram_addr_t pixel_addr(input logic [8:0] y, input logic [8:0] x);
        sram_addr_t yw;
        yw = sram_addr_t'(y);
        return (yw << 8) + (yw << 6) + sram_addr_t'(x);
    endfunction

endpackage

// File: rtl/frame_wr_fifo.sv
// Synchronous show-ahead FIFO buffering game writes until a free SRAM slot.
module frame_wr_fifo
    import frame_reader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wr_entry_t                push_data,
    input  logic                     pop,
    output wr_entry_t                pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wr_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_frame_reader.sv
// Scan-out reader for the 320x240 RGB555 SRAM frame buffer, interleaving game writes.
// FRAME_READER_WFIFO_EN selects a WFIFO_DEPTH-entry write FIFO instead of a single holding register.
module sram_frame_reader
    import frame_reader_pkg::*;
#(
    parameter int H_RES = H_RES_C,
    parameter int V_RES = V_RES_C
`ifdef FRAME_READER_WFIFO_EN
    ,
    parameter int WFIFO_DEPTH = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       x,
    input  logic [8:0]       y,
    input  logic             wr_req,
    input  logic [17:0]      wr_addr,
    input  logic [15:0]      wr_data,
    output logic             wr_ready,
    output logic [15:0]      pixel_data,
    inout  wire logic [15:0] sram_dq,
    output logic [17:0]      sram_addr,
    output logic             sram_we_n
);

    localparam logic [8:0] H_LIM = 9'(H_RES);
    localparam logic [8:0] V_LIM = 9'(V_RES);

    logic [8:0] x_q;
    slot_e      slot;
    slot_e      next_slot;
    logic       active;
    logic       rd_issue;
    logic       wr_issue;
    logic       rd_q;
    logic       pending;
    logic       wr_fire;
    wr_entry_t  wr_in;
    wr_entry_t  head;
    pixel_t     wdata_q;

    assign active    = (x < H_LIM) && (y < V_LIM);
    // A new x realigns the phase so every pixel starts with its READ slot.
    assign next_slot = (x != x_q) ? SLOT_READ :
                       (slot == SLOT_READ) ? SLOT_WRITE : SLOT_READ;
    assign rd_issue  = active && (next_slot == SLOT_READ);
    assign wr_issue  = !rd_issue && pending;
    assign wr_fire   = wr_req && wr_ready;
    assign wr_in     = '{addr: wr_addr, data: wr_data};

    assign sram_dq   = sram_we_n ? 16'hzzzz : wdata_q;

`ifdef FRAME_READER_WFIFO_EN
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(WFIFO_DEPTH):0]   fifo_count_unused;

    frame_wr_fifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_fire),
        .push_data (wr_in),
        .pop       (wr_issue),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    assign wr_ready = !rst && !fifo_full;
    assign pending  = !fifo_empty;
`else
    logic      hold_valid;
    wr_entry_t hold;

    // The entry stays owned until its strobe cycle has finished on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold       <= '0;
        end else if (wr_fire) begin
            hold_valid <= 1'b1;
            hold       <= wr_in;
        end else if (!sram_we_n) begin
            hold_valid <= 1'b0;
        end
    end

    assign wr_ready = !rst && !hold_valid;
    assign pending  = hold_valid && sram_we_n;
    assign head     = hold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            slot       <= SLOT_READ;
            rd_q       <= 1'b0;
            pixel_data <= '0;
            sram_addr  <= '0;
            sram_we_n  <= 1'b1;
            wdata_q    <= '0;
        end else begin
            x_q  <= x;
            slot <= next_slot;
            rd_q <= rd_issue;
            if (slot == SLOT_READ) begin
                pixel_data <= rd_q ? pixel_t'(sram_dq) : '0;
            end
            if (rd_issue) begin
                sram_addr <= pixel_addr(y, x);
                sram_we_n <= 1'b1;
            end else if (wr_issue) begin
                sram_addr <= head.addr;
                wdata_q   <= head.data;
                sram_we_n <= 1'b0;
            end else begin
                sram_we_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_frame_reader.sv
// Self-checking bench for sram_frame_reader with an asynchronous SRAM model and write scoreboard.
module tb_sram_frame_reader;

    localparam int W = 34;
`ifdef FRAME_READER_WFIFO_EN
    localparam int WR_GAP = 1;
`else
    localparam int WR_GAP = 3;
`endif

    logic        clk;
    logic        rst;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [15:0] pixel_data;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;

    logic [15:0]  mem [0:262143];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] send_q[$];
    int           wr_cyc[$];

    int  total;
    int  bad;
    int  cyc;
    int  wr_seen;
    int  stall_seen;
    bit  drv_en;

    sram_frame_reader dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .pixel_data (pixel_data),
        .sram_dq    (sram_dq),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n)
    );

    // Asynchronous SRAM: outputs the addressed word whenever not being written.
    assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [15:0] init_val(input int a);
        if (a == 1285) return 16'h7C1F;
        return 16'(a * 37 + 11);
    endfunction

    // write driver: records accepted writes into the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (drv_en && wr_req && !wr_ready) stall_seen++;
            if (drv_en && wr_req && wr_ready) begin
                exp_q.push_back({wr_addr, wr_data});
                void'(send_q.pop_front());
            end
            @(posedge clk);
            #1;
            if (drv_en) begin
                wr_req = (send_q.size() != 0);
                if (send_q.size() != 0) {wr_addr, wr_data} = send_q[0];
            end
        end
    end

    // scoreboard: every SRAM write strobe must match the oldest accepted write
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (sram_we_n === 1'b0) begin
                wr_seen++;
                wr_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write got addr=%0d data=%h, required no write", sram_addr, sram_dq);
                end else begin
                    e = exp_q.pop_front();
                    if ({sram_addr, sram_dq} !== e) begin
                        bad++;
                        $display("FAIL write_order got addr=%0d data=%h, required addr=%0d data=%h",
                                 sram_addr, sram_dq, e[33:16], e[15:0]);
                    end
                end
                mem[sram_addr] = sram_dq;
            end
        end
    end

    task automatic visit_pixel(input int xv, input int yv);
        int ea;
        ea = yv * 320 + xv;
        x = 9'(xv);
        y = 9'(yv);
        @(posedge clk); #1;
        total++;
        if (sram_addr !== 18'(ea) || sram_we_n !== 1'b1) begin
            bad++;
            $display("FAIL read_addr got addr=%0d we_n=%b, required addr=%0d we_n=1", sram_addr, sram_we_n, ea);
        end
        @(posedge clk); #1;
        total++;
        if (pixel_data !== init_val(ea)) begin
            bad++;
            $display("FAIL read_data addr=%0d got %h, required %h", ea, pixel_data, init_val(ea));
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && send_q.size() == 0) break;
            @(posedge clk); #1;
        end
        total++;
        if (exp_q.size() != 0 || send_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got %0d queued %0d unsent, required 0 0", name, exp_q.size(), send_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_req = 1'b1;
        wr_addr = 18'd5;
        wr_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n got %b, required 1", sram_we_n); end
            total++;
            if (pixel_data !== 16'h0) begin bad++; $display("FAIL reset_pixel got %h, required 0", pixel_data); end
            total++;
            if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b, required 0", wr_ready); end
            total++;
            if (sram_addr !== 18'd0) begin bad++; $display("FAIL reset_addr got %0d, required 0", sram_addr); end
        end
        rst = 1'b0;
        wr_req = 1'b0;
        #1;
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL release_ready got %b, required 1", wr_ready); end
        total++;
        if (wr_seen != 0) begin bad++; $display("FAIL reset_no_write got %0d writes, required 0", wr_seen); end
        drv_en = 1'b1;
    endtask

    task automatic test_read();
        visit_pixel(4, 4);
        x = 9'd5;
        @(posedge clk); #1;
        total++;
        if (sram_addr !== 18'd1285 || sram_we_n !== 1'b1) begin
            bad++;
            $display("FAIL read_n1 got addr=%0d we_n=%b, required 1285 1", sram_addr, sram_we_n);
        end
        @(posedge clk); #1;
        total++;
        if (pixel_data !== 16'h7C1F) begin bad++; $display("FAIL read_n2 got %h, required 7c1f", pixel_data); end
        x = 9'd6;
        @(posedge clk); #1;
        total++;
        if (pixel_data !== 16'h7C1F) begin bad++; $display("FAIL read_n3 got %h, required 7c1f", pixel_data); end
        total++;
        if (sram_addr !== 18'd1286) begin bad++; $display("FAIL read_next_addr got %0d, required 1286", sram_addr); end
        @(posedge clk); #1;
        total++;
        if (pixel_data !== init_val(1286)) begin
            bad++;
            $display("FAIL read_next_data got %h, required %h", pixel_data, init_val(1286));
        end
        for (int i = 0; i < 4; i++) begin
            visit_pixel(int'($urandom_range(0, 319)), int'($urandom_range(30, 200)));
        end
    endtask

    task automatic test_interleave();
        int w0;
        w0 = wr_seen;
        send_q.push_back({18'd10, 16'd1});
        send_q.push_back({18'd11, 16'd2});
        send_q.push_back({18'd12, 16'd3});
        for (int i = 0; i < 12; i++) visit_pixel(i, 20);
        wait_drain("interleave");
        total++;
        if (wr_seen - w0 != 3) begin bad++; $display("FAIL interleave_count got %0d, required 3", wr_seen - w0); end
    endtask

    task automatic test_blanking();
        int w0;
        logic [17:0] prev;
        w0 = wr_seen;
        wr_cyc.delete();
        x = 9'd330;
        y = 9'd20;
        for (int i = 0; i < 4; i++) send_q.push_back({18'(100 + i), 16'(16'hA000 + i)});
        @(posedge clk); #1;
        prev = sram_addr;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            total++;
            if (pixel_data !== 16'h0) begin bad++; $display("FAIL blank_pixel got %h, required 0", pixel_data); end
            if (sram_we_n === 1'b1) begin
                total++;
                if (sram_addr !== prev) begin
                    bad++;
                    $display("FAIL blank_no_read got addr=%0d, required held %0d", sram_addr, prev);
                end
            end
            prev = sram_addr;
        end
        wait_drain("blank");
        total++;
        if (wr_seen - w0 != 4) begin bad++; $display("FAIL blank_count got %0d, required 4", wr_seen - w0); end
        for (int i = 1; i < wr_cyc.size(); i++) begin
            total++;
            if (wr_cyc[i] - wr_cyc[i-1] != WR_GAP) begin
                bad++;
                $display("FAIL blank_spacing got %0d, required %0d", wr_cyc[i] - wr_cyc[i-1], WR_GAP);
            end
        end
    endtask

`ifdef FRAME_READER_WFIFO_EN
    task automatic test_full();
        int w0;
        w0 = wr_seen;
        stall_seen = 0;
        for (int i = 0; i < 10; i++) send_q.push_back({18'(200 + i), 16'(16'h0B00 + i)});
        for (int i = 0; i < 14; i++) visit_pixel(i, 30);
        wait_drain("full");
        total++;
        if (stall_seen == 0) begin bad++; $display("FAIL full_backpressure got 0 stalls, required >0"); end
        total++;
        if (wr_seen - w0 != 10) begin bad++; $display("FAIL full_count got %0d, required 10", wr_seen - w0); end
    endtask
`endif

    task automatic test_wrap_reset();
        bit found;
        int w0;
        visit_pixel(319, 9);
        visit_pixel(0, 10);
        for (int i = 0; i < 4; i++) send_q.push_back({18'(300 + i), 16'(16'h0C00 + i)});
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sram_we_n === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL wrap_write_timeout got no write in 40 cycles, required one"); end
        drv_en = 1'b0;
        wr_req = 1'b0;
        send_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rst_mid_write got we_n=%b, required 1", sram_we_n); end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        x = 9'd330;
        w0 = wr_seen;
        #1;
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst2_ready got %b, required 1", wr_ready); end
        repeat (10) begin
            @(posedge clk); #1;
        end
        total++;
        if (wr_seen != w0) begin bad++; $display("FAIL rst_flush got %0d writes, required 0", wr_seen - w0); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        wr_seen = 0;
        stall_seen = 0;
        drv_en = 1'b0;
        rst = 1'b1;
        x = '0;
        y = '0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < 262144; i++) mem[i] = init_val(i);
        test_reset();
        test_read();
        test_interleave();
        test_blanking();
`ifdef FRAME_READER_WFIFO_EN
        test_full();
`endif
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
